// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared encodings for the UART command controller: FSM state
//               values, command codes, default sync/response bytes and the
//               negative-acknowledge payload.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GET_CMD  = 4'd1,
        ST_GET_ADDR = 4'd2,
        ST_GET_DATA = 4'd3,
        ST_EXEC     = 4'd4,
        ST_SEND_HDR = 4'd5,
        ST_WAIT_HDR = 4'd6,
        ST_SEND_PLD = 4'd7,
        ST_WAIT_PLD = 4'd8
    } state_t;

    localparam logic [7:0] c_cmd_wr       = 8'h01;
    localparam logic [7:0] c_cmd_rd       = 8'h02;
    localparam logic [7:0] c_sync_default = 8'hA5;
    localparam logic [7:0] c_rsp_default  = 8'h5A;
    localparam logic [7:0] c_nak          = 8'hEE;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Parses host frames (SYNC, CMD, ADDR[, DATA]) from the uart_rx
//               byte stream, performs one register write or read on the 8-bit
//               register bus, and paces the two-byte reply (RSP, payload) into
//               uart_tx one byte at a time.
// Revision    : 1.0 - initial release
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   rx_data_avail/_byte   received byte strobe and value
//   rx_error              framing error strobe for the current rx byte
//   tx_active, tx_done    uart_tx busy level and byte-finished strobe
//   tx_data_avail/_byte   load strobe and byte for uart_tx
//   reg_wr/addr/wdata     register bus write strobe, address, write data
//   reg_rdata             register read data (combinational from reg_addr)
//   busy                  high whenever a frame or reply is in progress
//   frame_err             one-cycle pulse when a frame is aborted
// ============================================================================
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = 34720,
    parameter logic [7:0] SYNC_BYTE    = c_sync_default,
    parameter logic [7:0] RSP_BYTE     = c_rsp_default
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_data_avail,
    input  logic [7:0] rx_data_byte,
    input  logic       rx_error,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       tx_data_avail,
    output logic [7:0] tx_data_byte,
    output logic       reg_wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_err
);

    localparam int                c_tw      = $clog2(TIMEOUT_CLKS);
    localparam logic [c_tw-1:0]   c_to_last = c_tw'(TIMEOUT_CLKS - 1);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_cmd;
    logic [7:0]      r_addr;
    logic [7:0]      r_wdata;
    logic [7:0]      r_payload;
    logic [7:0]      r_tx_byte;
    logic            r_frame_err;
    logic [c_tw-1:0] r_to_cnt;

    logic w_in_get;
    logic w_rx_byte;
    logic w_timeout;
    logic w_abort;

    assign w_in_get  = (r_state == ST_GET_CMD) || (r_state == ST_GET_ADDR) ||
                       (r_state == ST_GET_DATA);
    // A framing error suppresses the byte delivered in the same cycle.
    assign w_rx_byte = rx_data_avail && !rx_error;
    // An arriving byte takes precedence over an expiring timeout.
    assign w_timeout = w_in_get && !rx_data_avail && !rx_error && (r_to_cnt == c_to_last);
    assign w_abort   = w_in_get && (rx_error || w_timeout);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        tx_data_avail = 1'b0;
        reg_wr        = 1'b0;
        busy          = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_rx_byte && (rx_data_byte == SYNC_BYTE)) begin
                    w_next = ST_GET_CMD;
                end
            end
            ST_GET_CMD: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (w_rx_byte) begin
                    w_next = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (w_rx_byte) begin
                    // Only a write carries a DATA byte; reads and illegal
                    // commands go straight to execution.
                    w_next = (r_cmd == c_cmd_wr) ? ST_GET_DATA : ST_EXEC;
                end
            end
            ST_GET_DATA: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (w_rx_byte) begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                reg_wr = (r_cmd == c_cmd_wr);
                w_next = ST_SEND_HDR;
            end
            ST_SEND_HDR: begin
                if (!tx_active) begin
                    tx_data_avail = 1'b1;
                    w_next        = ST_WAIT_HDR;
                end
            end
            ST_WAIT_HDR: begin
                if (tx_done) begin
                    w_next = ST_SEND_PLD;
                end
            end
            ST_SEND_PLD: begin
                if (!tx_active) begin
                    tx_data_avail = 1'b1;
                    w_next        = ST_WAIT_PLD;
                end
            end
            ST_WAIT_PLD: begin
                if (tx_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmd       <= 8'h00;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_payload   <= 8'h00;
            r_tx_byte   <= 8'h00;
            r_frame_err <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_frame_err <= w_abort;

            if (!w_in_get || rx_data_avail) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_tw'(1);
            end

            case (r_state)
                ST_GET_CMD: begin
                    if (w_rx_byte) r_cmd <= rx_data_byte;
                end
                ST_GET_ADDR: begin
                    if (w_rx_byte) r_addr <= rx_data_byte;
                end
                ST_GET_DATA: begin
                    if (w_rx_byte) r_wdata <= rx_data_byte;
                end
                ST_EXEC: begin
                    // The header byte is presented here so it is already
                    // stable when the load strobe fires in SEND_HDR.
                    r_tx_byte <= RSP_BYTE;
                    if (r_cmd == c_cmd_wr) begin
                        r_payload <= 8'h00;
                    end else if (r_cmd == c_cmd_rd) begin
                        r_payload <= reg_rdata;
                    end else begin
                        r_payload <= c_nak;
                    end
                end
                ST_WAIT_HDR: begin
                    // Swap to the payload only once the header has left.
                    if (tx_done) r_tx_byte <= r_payload;
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_data_byte = r_tx_byte;
    assign reg_addr     = r_addr;
    assign reg_wdata    = r_wdata;
    assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Scoreboard bench for uart_cmd_ctrl. Stimulus pushes expected
//               register writes, reply bytes and frame errors into queues; a
//               negedge monitor pops and compares whenever the DUT shows them.
//               A simple uart_tx model and a register array serve the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int TO = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_data_avail = 1'b0;
    logic [7:0] rx_data_byte = 8'h00;
    logic       rx_error = 1'b0;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_data_avail;
    logic [7:0] tx_data_byte;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_err;

    logic [7:0] bus_regs   [256];
    logic [7:0] model_regs [256];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr [$];
    logic [7:0] exp_tx [$];
    bit         exp_err [$];

    int   total = 0;
    int   bad   = 0;
    bit   tx_armed = 1'b0;
    logic [7:0] last_load = 8'h00;

    assign reg_rdata = bus_regs[reg_addr];

    always #5 clock = ~clock;

    uart_cmd_ctrl #(.TIMEOUT_CLKS(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data_avail(rx_data_avail),
        .rx_data_byte (rx_data_byte),
        .rx_error     (rx_error),
        .tx_active    (tx_active),
        .tx_done      (tx_done),
        .tx_data_avail(tx_data_avail),
        .tx_data_byte (tx_data_byte),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // uart_tx model: busy for 20 clocks after each load, then a done strobe.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && tx_data_avail) begin
                @(posedge clock);
                #1 tx_active = 1'b1;
                repeat (20) @(posedge clock);
                #1 tx_active = 1'b0;
                tx_done = 1'b1;
                @(posedge clock);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clock) begin
        wr_t        e;
        logic [7:0] b;
        if (reset) begin
            tx_armed = 1'b0;
        end else begin
            if (reg_wr) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL reg_wr_unexpected: got addr=%0h data=%0h expected none", reg_addr, reg_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", reg_addr, e.a);
                    chk("wr_data", reg_wdata, e.d);
                end
                bus_regs[reg_addr] = reg_wdata;
            end
            if (tx_data_avail) begin
                chk("tx_idle_at_load", tx_active, 1'b0);
                chk("tx_single_load", tx_armed, 1'b0);
                tx_armed  = 1'b1;
                last_load = tx_data_byte;
                if (exp_tx.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected: got %0h expected none", tx_data_byte);
                end else begin
                    b = exp_tx.pop_front();
                    chk("tx_byte", tx_data_byte, b);
                end
            end
            if (tx_done) begin
                if (tx_armed) chk("tx_hold", tx_data_byte, last_load);
                tx_armed = 1'b0;
            end
            if (frame_err) begin
                if (exp_err.size() == 0) begin
                    total++; bad++;
                    $display("FAIL frame_err_unexpected: got 1 expected 0");
                end else begin
                    void'(exp_err.pop_front());
                    total++;
                end
            end
        end
    end

    // Caller is aligned just after a posedge; gap = idle cycles before strobe.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit err);
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        rx_data_avail = 1'b1;
        rx_data_byte  = b;
        rx_error      = err;
        @(posedge clock);
        #1;
        rx_data_avail = 1'b0;
        rx_error      = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(nm, busy, 1'b0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input int gmax);
        bit is_wr;
        is_wr = (cmd == 8'h01);
        exp_tx.push_back(8'h5A);
        if (is_wr) begin
            exp_wr.push_back({addr, data});
            model_regs[addr] = data;
            exp_tx.push_back(8'h00);
        end else if (cmd == 8'h02) begin
            exp_tx.push_back(model_regs[addr]);
        end else begin
            exp_tx.push_back(8'hEE);
        end
        send_byte(8'hA5, $urandom_range(0, gmax), 1'b0);
        send_byte(cmd,   $urandom_range(0, gmax), 1'b0);
        send_byte(addr,  $urandom_range(0, gmax), 1'b0);
        if (is_wr) send_byte(data, $urandom_range(0, gmax), 1'b0);
        chk("busy_after_last_rx", busy, 1'b1);
        chk("reg_wr_latency", reg_wr, is_wr);
        chk("no_early_tx", tx_data_avail, 1'b0);
        wait_idle(400, "reply_done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] c;
        logic [7:0] s;
        for (int i = 0; i < 256; i++) begin
            bus_regs[i]   = 8'h00;
            model_regs[i] = 8'h00;
        end
        #1;
        chk("rst_tx_avail", tx_data_avail, 1'b0);
        chk("rst_tx_byte", tx_data_byte, 8'h00);
        chk("rst_reg_wr", reg_wr, 1'b0);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_wdata", reg_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Write, read-back, illegal command, then a normal read.
        do_frame(8'h01, 8'h03, 8'h7E, 0);
        do_frame(8'h02, 8'h03, 8'h00, 2);
        do_frame(8'h09, 8'h10, 8'h00, 1);
        do_frame(8'h02, 8'h10, 8'h00, 1);

        // Silence after CMD: frame aborted by the timeout, no reply.
        exp_err.push_back(1'b1);
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        n = 0;
        while (busy && n < TO + 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("timeout_idle", busy, 1'b0);
        chk("timeout_len_ok", (n >= TO - 1) && (n <= TO + 1), 1'b1);
        repeat (3) begin @(posedge clock); #1; end
        do_frame(8'h01, 8'h04, 8'h5C, 1);

        // Gaps just under the timeout are tolerated.
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'h5C);
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h02, TO - 10, 1'b0);
        send_byte(8'h04, TO - 10, 1'b0);
        wait_idle(400, "long_gap_reply");

        // Framing error on the address byte (same cycle as a data strobe).
        exp_err.push_back(1'b1);
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h03, 0, 1'b1);
        wait_idle(20, "rx_error_idle");

        // SYNC value inside a frame is plain data.
        do_frame(8'h01, 8'hA5, 8'hA5, 0);
        do_frame(8'h02, 8'hA5, 8'h00, 0);

        // Randomized frames, with stray bytes and errors while idle.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = 8'($urandom);
                while (s == 8'hA5) s = 8'($urandom);
                send_byte(s, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            end
            n = $urandom_range(0, 9);
            if (n < 4) begin
                c = 8'h01;
            end else if (n < 8) begin
                c = 8'h02;
            end else begin
                c = 8'($urandom);
                while (c == 8'h01 || c == 8'h02) c = 8'($urandom);
            end
            do_frame(c, 8'($urandom_range(0, 7)), 8'($urandom), 4);
        end

        // Reset while waiting for the header to finish.
        exp_tx.push_back(8'h5A);
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        n = 0;
        while (!tx_data_avail && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("hdr_seen", tx_data_avail, 1'b1);
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx_avail", tx_data_avail, 1'b0);
        chk("mid_rst_tx_byte", tx_data_byte, 8'h00);
        chk("mid_rst_reg_addr", reg_addr, 8'h00);
        chk("mid_rst_reg_wdata", reg_wdata, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_frame_err", frame_err, 1'b0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (60) @(posedge clock);
        #1;
        do_frame(8'h02, 8'h03, 8'h00, 1);

        repeat (10) @(posedge clock);
        #1;
        chk("exp_tx_left", exp_tx.size(), 0);
        chk("exp_wr_left", exp_wr.size(), 0);
        chk("exp_err_left", exp_err.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
